// File: rtl/sd_cdc_mbox_arb.sv
// sd_cdc_mbox_arb: source side of a shared clock-domain-crossing mailbox.
// Round-robin picks one srdy/drdy requester, captures its word into a held
// data register and runs a 4-phase req/ack handshake with the far domain.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | mailbox free; grant the next requester once ack_s is low
// REQ   | x_req high, x_data/x_src held; waiting for ack_s to rise
// DROP  | x_req low; waiting for ack_s to fall before the next grant
`timescale 1ns/1ps

module sd_cdc_mbox_arb #(
  parameter int inputs  = 4,
  parameter int width   = 32,
  parameter bit sync_en = 1'b1
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [inputs-1:0]         c_srdy,
  output logic [inputs-1:0]         c_drdy,
  input  logic [inputs*width-1:0]   c_data,
  output logic                      x_req,
  output logic [width-1:0]          x_data,
  output logic [$clog2(inputs)-1:0] x_src,
  input  logic                      x_ack,
  output logic                      busy
);

  localparam int src_w = $clog2(inputs);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DROP = 2'd2
  } state_t;

  state_t             state;
  logic [src_w-1:0]   ptr;
  logic               ack_s;
  logic               found;
  logic               grant;
  logic [src_w-1:0]   win;
  logic [src_w-1:0]   cand;
  logic [width-1:0]   win_data;
  int                 idx;

  generate
    if (sync_en) begin : g_sync
      logic sync_q1;
      logic sync_q2;
      // Two-flop synchronizer for the far-domain ack; left unreset on purpose
      // so a reset never fabricates an ack edge.
      always_ff @(posedge clk) begin
        sync_q1 <= x_ack;
        sync_q2 <= sync_q1;
      end
      assign ack_s = sync_q2;
    end else begin : g_nosync
      assign ack_s = x_ack;
    end
  endgenerate

  // Round-robin search starting one past the last winner, wrapping around.
  always_comb begin
    win   = '0;
    cand  = '0;
    found = 1'b0;
    idx   = 0;
    for (int i = 1; i <= inputs; i++) begin
      idx  = (int'(ptr) + i) % inputs;
      cand = src_w'(idx);
      if (!found && c_srdy[cand]) begin
        found = 1'b1;
        win   = cand;
      end
    end
  end

  // Select the winning requester's data word.
  always_comb begin
    win_data = '0;
    for (int i = 0; i < inputs; i++) begin
      if (win == src_w'(i)) begin
        win_data = c_data[i*width +: width];
      end
    end
  end

  // A stale ack (still high from the previous transfer) blocks the grant;
  // reset_n gating keeps c_drdy quiet while reset is held.
  assign grant = reset_n && (state == IDLE) && !ack_s && found;

  // One-hot accept, only in the granting cycle.
  always_comb begin
    c_drdy = '0;
    for (int i = 0; i < inputs; i++) begin
      c_drdy[i] = grant && (win == src_w'(i));
    end
  end

  assign busy = (state != IDLE);

  // Handshake FSM with registered request, data and source index.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state  <= IDLE;
      x_req  <= 1'b0;
      x_data <= '0;
      x_src  <= '0;
      ptr    <= src_w'(inputs - 1);
    end else begin
      case (state)
        IDLE: begin
          if (grant) begin
            x_data <= win_data;
            x_src  <= win;
            ptr    <= win;
            x_req  <= 1'b1;
            state  <= REQ;
          end
        end
        REQ: begin
          if (ack_s) begin
            x_req <= 1'b0;
            state <= DROP;
          end
        end
        DROP: begin
          if (!ack_s) begin
            state <= IDLE;
          end
        end
        default: begin
          x_req <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sd_cdc_mbox_arb.sv
// Bench for sd_cdc_mbox_arb: a synchronized instance with a 3-register
// responder, and an unsynchronized instance with a 1-register responder.
`timescale 1ns/1ps

module tb_sd_cdc_mbox_arb;

  localparam int N  = 4;
  localparam int W  = 32;
  localparam int SW = 2;

  typedef struct packed {
    logic [SW-1:0] src;
    logic [W-1:0]  data;
  } exp_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  int cyc_cnt = 0;
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  // instance A: sync_en=1
  logic [N-1:0]   c_srdy_a = '0;
  logic [N-1:0]   c_drdy_a;
  logic [N*W-1:0] c_data_a = '0;
  logic           x_req_a;
  logic [W-1:0]   x_data_a;
  logic [SW-1:0]  x_src_a;
  logic           x_ack_a;
  logic           busy_a;

  // instance B: sync_en=0
  logic [N-1:0]   c_srdy_b = '0;
  logic [N-1:0]   c_drdy_b;
  logic [N*W-1:0] c_data_b = '0;
  logic           x_req_b;
  logic [W-1:0]   x_data_b;
  logic [SW-1:0]  x_src_b;
  logic           x_ack_b;
  logic           busy_b;

  // far-side responders
  logic r1 = 1'b0, r2 = 1'b0, r3 = 1'b0, rb = 1'b0;
  logic force_ack = 1'b0;
  always @(posedge clk) begin
    r1 <= x_req_a;
    r2 <= r1;
    r3 <= r2;
    rb <= x_req_b;
  end
  assign x_ack_a = force_ack | r3;
  assign x_ack_b = rb;

  sd_cdc_mbox_arb #(.inputs(N), .width(W), .sync_en(1'b1)) dut_a (
    .clk(clk), .reset_n(reset_n), .c_srdy(c_srdy_a), .c_drdy(c_drdy_a),
    .c_data(c_data_a), .x_req(x_req_a), .x_data(x_data_a), .x_src(x_src_a),
    .x_ack(x_ack_a), .busy(busy_a));

  sd_cdc_mbox_arb #(.inputs(N), .width(W), .sync_en(1'b0)) dut_b (
    .clk(clk), .reset_n(reset_n), .c_srdy(c_srdy_b), .c_drdy(c_drdy_b),
    .c_data(c_data_b), .x_req(x_req_b), .x_data(x_data_b), .x_src(x_src_b),
    .x_ack(x_ack_b), .busy(busy_b));

  int   compared = 0;
  int   mismatched = 0;
  exp_t sb_a[$];
  exp_t sb_b[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp)
    else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] word_a(input int i);
    return 32'hA5A5_0000 + W'(i);
  endfunction

  function automatic logic [W-1:0] word_b(input int i);
    return 32'h5A5A_0000 + W'(i);
  endfunction

  function automatic exp_t mk(input int i, input logic [W-1:0] d);
    exp_t e;
    e.src  = SW'(i);
    e.data = d;
    return e;
  endfunction

  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_grant(input bit sel, input int idx, input int max_cyc, output int at_cyc);
    bit got;
    logic [N-1:0] d;
    got = 1'b0;
    d = '0;
    for (int n = 0; n < max_cyc; n++) begin
      @(negedge clk);
      d = sel ? c_drdy_b : c_drdy_a;
      if (d != '0) begin
        got = 1'b1;
        break;
      end
    end
    check("grant_seen", 64'(got), 64'(1));
    if (got) check("grant_onehot", 64'(d), 64'(N'(1) << idx));
    at_cyc = cyc_cnt;
  endtask

  task automatic wait_idle(input bit sel, input int max_cyc);
    bit got;
    got = 1'b0;
    for (int n = 0; n < max_cyc; n++) begin
      @(negedge clk);
      if (!(sel ? busy_b : busy_a)) begin
        got = 1'b1;
        break;
      end
    end
    check("idle_reached", 64'(got), 64'(1));
  endtask

  // Scoreboard pop on every new request, plus data/src hold while x_req stays high.
  logic          req_q_a = 1'b0, req_q_b = 1'b0;
  logic [W-1:0]  dq_a = '0, dq_b = '0;
  logic [SW-1:0] sq_a = '0, sq_b = '0;
  always @(negedge clk) begin : mon
    exp_t e;
    if (x_req_a && !req_q_a) begin
      check("sb_a_pending", 64'(sb_a.size() != 0), 64'(1));
      if (sb_a.size() != 0) begin
        e = sb_a.pop_front();
        check("x_src_a", 64'(x_src_a), 64'(e.src));
        check("x_data_a", 64'(x_data_a), 64'(e.data));
      end
    end
    if (x_req_a && req_q_a) begin
      check("hold_data_a", 64'(x_data_a), 64'(dq_a));
      check("hold_src_a", 64'(x_src_a), 64'(sq_a));
    end
    if (x_req_b && !req_q_b) begin
      check("sb_b_pending", 64'(sb_b.size() != 0), 64'(1));
      if (sb_b.size() != 0) begin
        e = sb_b.pop_front();
        check("x_src_b", 64'(x_src_b), 64'(e.src));
        check("x_data_b", 64'(x_data_b), 64'(e.data));
      end
    end
    if (x_req_b && req_q_b) begin
      check("hold_data_b", 64'(x_data_b), 64'(dq_b));
      check("hold_src_b", 64'(x_src_b), 64'(sq_b));
    end
    req_q_a <= x_req_a;
    dq_a    <= x_data_a;
    sq_a    <= x_src_a;
    req_q_b <= x_req_b;
    dq_b    <= x_data_b;
    sq_b    <= x_src_b;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int t, tp, tr;
    for (int i = 0; i < N; i++) begin
      c_data_a[i*W +: W] = word_a(i);
      c_data_b[i*W +: W] = word_b(i);
    end

    // reset state
    repeat (2) next_cyc();
    @(negedge clk);
    check("rst_x_req", 64'(x_req_a), 64'(0));
    check("rst_x_data", 64'(x_data_a), 64'(0));
    check("rst_x_src", 64'(x_src_a), 64'(0));
    check("rst_busy", 64'(busy_a), 64'(0));
    check("rst_x_req_b", 64'(x_req_b), 64'(0));
    next_cyc();
    c_srdy_a = 4'b1111;
    @(negedge clk);
    check("rst_drdy_gated", 64'(c_drdy_a), 64'(0));
    next_cyc();
    c_srdy_a = '0;
    reset_n = 1'b1;

    // 1: single transfer timing
    next_cyc();
    c_srdy_a = 4'b0100;
    sb_a.push_back(mk(2, word_a(2)));
    wait_grant(1'b0, 2, 1, t);
    check("t1_busy_c0", 64'(busy_a), 64'(0));
    next_cyc();
    c_srdy_a = '0;
    for (int c = 1; c <= 13; c++) begin
      @(negedge clk);
      check("t1_x_req", 64'(x_req_a), 64'(c <= 6));
      check("t1_busy", 64'(busy_a), 64'(c <= 12));
      check("t1_drdy", 64'(c_drdy_a), 64'(0));
      if (c >= 7) begin
        check("t1_data_kept", 64'(x_data_a), 64'(32'hA5A5_0002));
        check("t1_src_kept", 64'(x_src_a), 64'(2));
      end
    end

    // 2: round-robin with all requesting, fresh pointer
    next_cyc();
    reset_n = 1'b0;
    repeat (2) next_cyc();
    reset_n = 1'b1;
    c_srdy_a = 4'b1111;
    for (int k = 0; k < 6; k++) sb_a.push_back(mk(k % 4, word_a(k % 4)));
    tp = 0;
    for (int k = 0; k < 6; k++) begin
      wait_grant(1'b0, k % 4, 14, t);
      if (k > 0) check("rr_period", 64'(t - tp), 64'(13));
      tp = t;
    end
    next_cyc();
    c_srdy_a = '0;
    wait_idle(1'b0, 20);

    // 3: wrap after a grant to 3
    next_cyc();
    c_srdy_a = 4'b1000;
    sb_a.push_back(mk(3, word_a(3)));
    wait_grant(1'b0, 3, 2, t);
    next_cyc();
    c_srdy_a = 4'b0011;
    sb_a.push_back(mk(0, word_a(0)));
    sb_a.push_back(mk(1, word_a(1)));
    wait_grant(1'b0, 0, 14, t);
    wait_grant(1'b0, 1, 14, t);
    next_cyc();
    c_srdy_a = '0;
    wait_idle(1'b0, 20);

    // 4: stale ack blocks grant; release shows after the two sync stages
    next_cyc();
    force_ack = 1'b1;
    repeat (3) next_cyc();
    c_srdy_a = 4'b0001;
    sb_a.push_back(mk(0, word_a(0)));
    repeat (4) begin
      @(negedge clk);
      check("stale_drdy", 64'(c_drdy_a), 64'(0));
      check("stale_busy", 64'(busy_a), 64'(0));
    end
    next_cyc();
    force_ack = 1'b0;
    tr = cyc_cnt;
    @(negedge clk);
    check("stale_release_drdy", 64'(c_drdy_a), 64'(0));
    wait_grant(1'b0, 0, 4, t);
    check("stale_latency", 64'(t - tr), 64'(2));
    next_cyc();
    c_srdy_a = '0;
    wait_idle(1'b0, 20);

    // 5: reset in the middle of a request
    next_cyc();
    c_srdy_a = 4'b0010;
    sb_a.push_back(mk(1, word_a(1)));
    wait_grant(1'b0, 1, 2, t);
    next_cyc();
    c_srdy_a = '0;
    next_cyc();
    next_cyc();
    reset_n = 1'b0;
    c_srdy_a = 4'b1000;
    @(negedge clk);
    check("pre_reset_req", 64'(x_req_a), 64'(1));
    next_cyc();
    @(negedge clk);
    check("mid_rst_x_req", 64'(x_req_a), 64'(0));
    check("mid_rst_busy", 64'(busy_a), 64'(0));
    check("mid_rst_drdy", 64'(c_drdy_a), 64'(0));
    check("mid_rst_x_data", 64'(x_data_a), 64'(0));
    check("mid_rst_x_src", 64'(x_src_a), 64'(0));
    repeat (8) next_cyc();
    reset_n = 1'b1;
    sb_a.push_back(mk(3, word_a(3)));
    wait_grant(1'b0, 3, 4, t);
    next_cyc();
    c_srdy_a = '0;
    wait_idle(1'b0, 20);

    // 6: unsynchronized ack, 5-cycle period
    next_cyc();
    c_srdy_b = 4'b0101;
    sb_b.push_back(mk(0, word_b(0)));
    sb_b.push_back(mk(2, word_b(2)));
    sb_b.push_back(mk(0, word_b(0)));
    tp = 0;
    for (int k = 0; k < 3; k++) begin
      wait_grant(1'b1, (k == 1) ? 2 : 0, 8, t);
      if (k > 0) check("nosync_period", 64'(t - tp), 64'(5));
      tp = t;
    end
    next_cyc();
    c_srdy_b = '0;
    wait_idle(1'b1, 10);

    repeat (2) next_cyc();
    check("sb_a_drained", 64'(sb_a.size()), 64'(0));
    check("sb_b_drained", 64'(sb_b.size()), 64'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
